fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the MIPS32 pipeline. It replaces the fixed two-stage, two-operand comparator with an internal destination-tag pipeline covering NUM_FWD_STAGES post-EX pipeline registers and NUM_SRC operands. It raises the ID-stage stall for consumers whose producer has not yet reached a stage that carries its result, and registers the per-operand forwarding selects into EX. It sits between the decoder (ID inputs) and the EX operand muxes, and exports a stall counter for performance debug.

---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_src_lookup.sv | 43 ++++
 rtl/fwd_hazard_unit.sv | 115 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: select encoding,
// select-width derivation and the destination-tag entry.
package fwd_pkg;

  localparam int FWD_SEL_RF    = 0;
  // Tag fields are sized for the widest supported configuration.
  localparam int FWD_RD_W_MAX  = 8;
  localparam int FWD_RDY_W_MAX = 4;

  function automatic int fwd_sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic                     wb;
    logic [FWD_RD_W_MAX-1:0]  rd;
    logic [FWD_RDY_W_MAX-1:0] rdy;
  } fwd_tag_t;

  localparam fwd_tag_t FWD_TAG_IDLE = '{
    valid: 1'b0,
    wb:    1'b0,
    rd:    {FWD_RD_W_MAX{1'b0}},
    rdy:   {FWD_RDY_W_MAX{1'b0}}
  };

endpackage

// File: rtl/fwd_src_lookup.sv
// Priority compare of one source operand against every tag entry;
// the youngest matching producer decides the select or the hazard.
module fwd_src_lookup
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_SIZE  = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int SEL_W          = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  logic [REG_ADDR_SIZE-1:0]       i_src,
  input  logic                           i_used,
  input  fwd_tag_t [NUM_FWD_STAGES-1:0]  i_tags,
  output logic [SEL_W-1:0]               o_sel,
  output logic                           o_hazard
);

  // Walk oldest to youngest so the lowest matching entry has the last word.
  always_comb begin
    o_sel    = SEL_W'(FWD_SEL_RF);
    o_hazard = 1'b0;
    if (i_used && (i_src != {REG_ADDR_SIZE{1'b0}})) begin
      for (int j = NUM_FWD_STAGES - 1; j >= 0; j--) begin
        if (i_tags[j].valid && i_tags[j].wb &&
            (i_tags[j].rd == FWD_RD_W_MAX'(i_src))) begin
          if (FWD_RDY_W_MAX'(j + 1) >= i_tags[j].rdy) begin
            o_sel    = SEL_W'(j + 1);
            o_hazard = 1'b0;
          end else begin
            o_sel    = SEL_W'(FWD_SEL_RF);
            o_hazard = 1'b1;
          end
        end else begin
          o_sel    = o_sel;
          o_hazard = o_hazard;
        end
      end
    end else begin
      o_sel    = SEL_W'(FWD_SEL_RF);
      o_hazard = 1'b0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generation for the MIPS32 pipeline,
// driven by a destination-tag pipeline mirroring the post-EX registers.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_SIZE  = 5,
  parameter int NUM_SRC        = 3,
  parameter int NUM_FWD_STAGES = 2,
  parameter int CNT_W          = 16,
  parameter int SEL_W          = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_freeze,
  input  logic                             i_flush,
  input  logic                             i_id_valid,
  input  logic [NUM_SRC*REG_ADDR_SIZE-1:0] i_id_src,
  input  logic [NUM_SRC-1:0]               i_id_src_used,
  input  logic                             i_id_wb,
  input  logic [REG_ADDR_SIZE-1:0]         i_id_rd,
  input  logic [SEL_W-1:0]                 i_id_rdy_stage,
  output logic                             o_stall,
  output logic [NUM_SRC*SEL_W-1:0]         o_ex_src_sel,
  output logic [CNT_W-1:0]                 o_stall_cnt
);

  fwd_tag_t [NUM_FWD_STAGES-1:0] tag_q, tag_d;
  logic [NUM_SRC*SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [NUM_SRC*SEL_W-1:0]      lookup_sel_s;
  logic [NUM_SRC-1:0]            hazard_s;
  logic [FWD_RDY_W_MAX-1:0]      rdy_s;
  logic                          stall_s;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_lookup #(
      .REG_ADDR_SIZE  (REG_ADDR_SIZE),
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .SEL_W          (SEL_W)
    ) u_lookup (
      .i_src    (i_id_src[s*REG_ADDR_SIZE +: REG_ADDR_SIZE]),
      .i_used   (i_id_src_used[s]),
      .i_tags   (tag_q),
      .o_sel    (lookup_sel_s[s*SEL_W +: SEL_W]),
      .o_hazard (hazard_s[s])
    );
  end

  // Ready stage 0 means "ALU result"; anything past the last register is clamped.
  always_comb begin
    rdy_s = FWD_RDY_W_MAX'(1);
    if (i_id_rdy_stage == {SEL_W{1'b0}}) begin
      rdy_s = FWD_RDY_W_MAX'(1);
    end else if (i_id_rdy_stage > SEL_W'(NUM_FWD_STAGES)) begin
      rdy_s = FWD_RDY_W_MAX'(NUM_FWD_STAGES);
    end else begin
      rdy_s = FWD_RDY_W_MAX'(i_id_rdy_stage);
    end
  end

  // Flush kills the instruction leaving ID, so it never stalls.
  always_comb begin
    stall_s = i_id_valid && (|hazard_s) && !i_flush;
    o_stall = stall_s;
  end

  // Next state: shift tags, load entry 0 / selects, count stall cycles.
  always_comb begin
    tag_d = tag_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (!i_freeze) begin
      for (int j = NUM_FWD_STAGES - 1; j >= 1; j--) begin
        tag_d[j] = tag_q[j-1];
      end
      if (i_flush || stall_s) begin
        tag_d[0] = FWD_TAG_IDLE;
        sel_d    = {(NUM_SRC*SEL_W){1'b0}};
      end else begin
        tag_d[0].valid = i_id_valid;
        tag_d[0].wb    = i_id_wb;
        tag_d[0].rd    = FWD_RD_W_MAX'(i_id_rd);
        tag_d[0].rdy   = rdy_s;
        sel_d          = lookup_sel_s;
      end
      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      tag_d = tag_q;
      sel_d = sel_q;
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tag_q <= {NUM_FWD_STAGES{FWD_TAG_IDLE}};
      sel_q <= {(NUM_SRC*SEL_W){1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      tag_q <= tag_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_ex_src_sel = sel_q;
  assign o_stall_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default-parameter instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset_n;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic [14:0] id_src;
  logic [2:0]  id_used;
  logic        id_wb;
  logic [4:0]  id_rd;
  logic [1:0]  id_rdy;

  logic        stall;
  logic [5:0]  sel;
  logic [15:0] cnt;
  logic        stall4;
  logic [5:0]  sel4;
  logic [3:0]  cnt4;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  fwd_hazard_unit dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_freeze       (freeze),
    .i_flush        (flush),
    .i_id_valid     (id_valid),
    .i_id_src       (id_src),
    .i_id_src_used  (id_used),
    .i_id_wb        (id_wb),
    .i_id_rd        (id_rd),
    .i_id_rdy_stage (id_rdy),
    .o_stall        (stall),
    .o_ex_src_sel   (sel),
    .o_stall_cnt    (cnt)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_c4 (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_freeze       (freeze),
    .i_flush        (flush),
    .i_id_valid     (id_valid),
    .i_id_src       (id_src),
    .i_id_src_used  (id_used),
    .i_id_wb        (id_wb),
    .i_id_rd        (id_rd),
    .i_id_rdy_stage (id_rdy),
    .o_stall        (stall4),
    .o_ex_src_sel   (sel4),
    .o_stall_cnt    (cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic v, input logic wb, input logic [4:0] rd, input logic [1:0] rdy,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [2:0] used);
    id_valid = v;
    id_wb    = wb;
    id_rd    = rd;
    id_rdy   = rdy;
    id_src   = {s2, s1, s0};
    id_used  = used;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ins(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    tick();
  endtask

  initial begin
    clk     = 1'b0;
    reset_n = 1'b0;
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      freeze   = 1'($urandom);
      flush    = 1'($urandom);
      id_valid = 1'($urandom);
      id_src   = 15'($urandom);
      id_used  = 3'($urandom);
      id_wb    = 1'($urandom);
      id_rd    = 5'($urandom);
      id_rdy   = 2'($urandom);
      @(negedge clk);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
    end
    @(posedge clk);
    #1;
    freeze = 1'b0;
    flush  = 1'b0;
    ins(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    reset_n = 1'b1;
    tick();

    // ALU back-to-back: add r3 then sub reads r3
    ins(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd4, 2'd1, 5'd3, 5'd0, 5'd0, 3'b001);
    chk("alu_b2b_stall", 32'(stall), 32'h0);
    tick();
    chk("alu_b2b_sel", 32'(sel), 32'h01);
    drain();

    // One gap instruction
    ins(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b0, 5'd0, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd4, 2'd1, 5'd3, 5'd0, 5'd0, 3'b001);
    chk("alu_gap1_stall", 32'(stall), 32'h0);
    tick();
    chk("alu_gap1_sel", 32'(sel), 32'h02);
    drain();

    // Two gaps: producer already in the register file
    ins(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b0, 5'd0, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    tick();
    ins(1'b1, 1'b1, 5'd4, 2'd1, 5'd3, 5'd0, 5'd0, 3'b001);
    tick();
    chk("alu_gap2_sel", 32'(sel), 32'h00);
    chk("alu_cnt0", 32'(cnt), 32'h0);
    drain();

    // Load-use: lw r5 then consumer on src1
    ins(1'b1, 1'b1, 5'd5, 2'd2, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 5'd5, 5'd0, 3'b010);
    chk("lu_stall", 32'(stall), 32'h1);
    tick();
    chk("lu_bubble_sel", 32'(sel), 32'h00);
    chk("lu_stall_clear", 32'(stall), 32'h0);
    chk("lu_cnt", 32'(cnt), 32'h1);
    chk("lu_cnt4", 32'(cnt4), 32'h1);
    tick();
    chk("lu_sel", 32'(sel), 32'h08);
    drain();

    // Youngest producer wins; r0 and unused operands ignored
    ins(1'b1, 1'b1, 5'd7, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd7, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd8, 2'd1, 5'd7, 5'd0, 5'd7, 3'b011);
    chk("young_stall", 32'(stall), 32'h0);
    tick();
    chk("young_sel", 32'(sel), 32'h01);
    drain();
    ins(1'b1, 1'b1, 5'd0, 2'd2, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd8, 2'd1, 5'd0, 5'd0, 5'd0, 3'b111);
    chk("r0_stall", 32'(stall), 32'h0);
    tick();
    chk("r0_sel", 32'(sel), 32'h00);
    drain();
    ins(1'b1, 1'b1, 5'd7, 2'd2, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd8, 2'd1, 5'd0, 5'd0, 5'd7, 3'b011);
    chk("unused_stall", 32'(stall), 32'h0);
    drain();

    // Freeze during a load-use stall
    ins(1'b1, 1'b1, 5'd9, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd5, 2'd2, 5'd9, 5'd0, 5'd0, 3'b001);
    tick();
    chk("frz_pre_sel", 32'(sel), 32'h01);
    freeze = 1'b1;
    ins(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 5'd5, 5'd0, 3'b010);
    chk("frz_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_sel_hold", 32'(sel), 32'h01);
      chk("frz_cnt_hold", 32'(cnt), 32'h1);
      chk("frz_stall_hold", 32'(stall), 32'h1);
    end
    freeze = 1'b0;
    tick();
    chk("frz_rel_sel", 32'(sel), 32'h00);
    chk("frz_rel_cnt", 32'(cnt), 32'h2);
    chk("frz_rel_stall", 32'(stall), 32'h0);
    tick();
    chk("frz_fwd_sel", 32'(sel), 32'h08);
    drain();

    // Flush together with a hazard
    ins(1'b1, 1'b1, 5'd5, 2'd2, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    flush = 1'b1;
    ins(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 5'd5, 5'd0, 3'b010);
    chk("flush_hz_stall", 32'(stall), 32'h0);
    tick();
    flush = 1'b0;
    chk("flush_hz_sel", 32'(sel), 32'h00);
    chk("flush_hz_cnt", 32'(cnt), 32'h2);
    drain();

    // Flush without hazard inserts one bubble
    ins(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    flush = 1'b1;
    ins(1'b1, 1'b1, 5'd4, 2'd1, 5'd3, 5'd0, 5'd0, 3'b001);
    tick();
    flush = 1'b0;
    chk("flush_sel", 32'(sel), 32'h00);
    ins(1'b1, 1'b1, 5'd4, 2'd1, 5'd3, 5'd0, 5'd0, 3'b001);
    tick();
    chk("flush_after_sel", 32'(sel), 32'h02);
    drain();

    // Twenty load-use stalls: 16-bit counter reaches 22, 4-bit saturates
    for (int i = 0; i < 20; i++) begin
      ins(1'b1, 1'b1, 5'd5, 2'd2, 5'd0, 5'd0, 5'd0, 3'b000);
      tick();
      ins(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 5'd5, 5'd0, 3'b010);
      chk("sat_stall", 32'(stall), 32'h1);
      tick();
      tick();
    end
    chk("sat_cnt16", 32'(cnt), 32'd22);
    chk("sat_cnt4", 32'(cnt4), 32'd15);
    drain();

    // Reset asserted mid-stall
    ins(1'b1, 1'b1, 5'd5, 2'd2, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    ins(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 5'd5, 5'd0, 3'b010);
    chk("mid_rst_pre_stall", 32'(stall), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_cnt", 32'(cnt), 32'h0);
    chk("mid_rst_cnt4", 32'(cnt4), 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst_stall", 32'(stall), 32'h0);
    tick();
    chk("post_rst_sel", 32'(sel), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
